// File: rtl/xlr8_dm_master.sv
`default_nettype none
// ============================================================================
// xlr8_dm_master : queued initiator that drives the XB data-memory register bus
// Revision 1.0
// ============================================================================
module xlr8_dm_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clken,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic [7:0] cmd_addr,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic       busy,
    output logic [7:0] ramadr,
    output logic       ramre,
    output logic       ramwe,
    output logic       dm_sel,
    output logic [7:0] dbus_out,
    input  logic [7:0] dbus_in,
    input  logic       io_out_en
);

    localparam int              AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int              CW       = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0]   FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [16:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push;
    logic [16:0]   head;

    logic [1:0]    state;
    logic [1:0]    state_nx;
    logic          cur_write;
    logic [7:0]    timeout_cnt;
    logic          to_last;

    logic          pop;
    logic          finish;
    logic          rd_hit;
    logic          to_err;
    logic          cnt_inc;
    logic          rsp_done;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign cmd_ready = !full && !rst;
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign to_last   = (timeout_cnt == TO_LAST);
    assign busy      = !empty || (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (!empty) state_nx = S_ISSUE;
            S_ISSUE: if (finish) state_nx = S_RESP;
            S_RESP:  if (rsp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // io_out_en is checked before the timeout so a response on the last counted cycle wins
    always_comb begin
        pop      = (state == S_IDLE) && !empty;
        rd_hit   = (state == S_ISSUE) && clken && !cur_write && io_out_en;
        to_err   = (state == S_ISSUE) && clken && !cur_write && !io_out_en && to_last;
        cnt_inc  = (state == S_ISSUE) && clken && !cur_write && !io_out_en && !to_last;
        finish   = (state == S_ISSUE) && clken && (cur_write || io_out_en || to_last);
        rsp_done = (state == S_RESP) && rsp_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            cur_write   <= 1'b0;
            timeout_cnt <= '0;
            ramadr      <= '0;
            ramre       <= 1'b0;
            ramwe       <= 1'b0;
            dm_sel      <= 1'b0;
            dbus_out    <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (pop) begin
                cur_write   <= head[16];
                ramadr      <= head[15:8];
                ramwe       <= head[16];
                ramre       <= !head[16];
                dm_sel      <= 1'b1;
                dbus_out    <= head[16] ? head[7:0] : 8'h00;
                timeout_cnt <= '0;
            end

            if (cnt_inc) timeout_cnt <= timeout_cnt + 1'b1;

            if (finish) begin
                ramadr    <= '0;
                ramre     <= 1'b0;
                ramwe     <= 1'b0;
                dm_sel    <= 1'b0;
                dbus_out  <= '0;
                rsp_valid <= 1'b1;
                rsp_rdata <= rd_hit ? dbus_in : 8'h00;
                rsp_err   <= to_err;
            end

            if (rsp_done) rsp_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_xlr8_dm_master.sv
`default_nettype none
// ============================================================================
// tb_xlr8_dm_master : directed vector bench for the DM bus initiator
// Revision 1.0
// ============================================================================
module tb_xlr8_dm_master;

    localparam int FIFO_DEPTH = 4;
    localparam int TIMEOUT    = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       clken;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic [7:0] ramadr;
    logic       ramre;
    logic       ramwe;
    logic       dm_sel;
    logic [7:0] dbus_out;
    logic [7:0] dbus_in;
    logic       io_out_en;

    logic       auto_resp;
    logic       io_drv;
    logic [7:0] dbus_drv;

    // auto_resp models a combinational responder returning addr^0x5A
    assign io_out_en = auto_resp ? ramre : io_drv;
    assign dbus_in   = auto_resp ? (ramadr ^ 8'h5A) : dbus_drv;

    always #5 clk = ~clk;

    xlr8_dm_master #(.FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .clken(clken),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .ramadr(ramadr), .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
        .dbus_out(dbus_out), .dbus_in(dbus_in), .io_out_en(io_out_en)
    );

    typedef struct {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] din;
        int         en_cyc;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_strobes;
    } vec_t;

    vec_t vt[7];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic wr, input logic [7:0] addr, input logic [7:0] wdata, input string tag);
        check({tag, "_cmd_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        int strobes;
        clken     = 1'b1;
        rsp_ready = 1'b0;
        io_drv    = 1'b0;
        dbus_drv  = v.din;
        push(v.wr, v.addr, v.wdata, tag);
        tick();
        check({tag, "_ramwe"}, ramwe, v.wr);
        check({tag, "_ramre"}, ramre, !v.wr);
        check({tag, "_dm_sel"}, dm_sel, 1);
        check({tag, "_ramadr"}, ramadr, v.addr);
        if (v.wr) check({tag, "_dbus_out"}, dbus_out, v.wdata);
        strobes = 0;
        while ((ramre || ramwe) && strobes < 40) begin
            strobes++;
            io_drv = (v.en_cyc == strobes);
            tick();
        end
        io_drv = 1'b0;
        check({tag, "_strobe_cycles"}, strobes, v.exp_strobes);
        check({tag, "_rsp_valid"}, rsp_valid, 1);
        check({tag, "_rsp_rdata"}, rsp_rdata, v.exp_rdata);
        check({tag, "_rsp_err"}, rsp_err, v.exp_err);
        check({tag, "_bus_idle"}, {dm_sel, ramre, ramwe, dbus_out}, 0);
        tick();
        check({tag, "_rsp_hold"}, {rsp_valid, rsp_err, rsp_rdata}, {1'b1, v.exp_err, v.exp_rdata});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_rsp_drop"}, rsp_valid, 0);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        int seen;

        vt[0] = '{1'b1, 8'h40, 8'hA5, 8'h00, 0,  8'h00, 1'b0, 1};
        vt[1] = '{1'b0, 8'h41, 8'h00, 8'h3C, 1,  8'h3C, 1'b0, 1};
        vt[2] = '{1'b0, 8'h7F, 8'h00, 8'hEE, 0,  8'h00, 1'b1, 15};
        vt[3] = '{1'b0, 8'h20, 8'h00, 8'hC3, 15, 8'hC3, 1'b0, 15};
        vt[4] = '{1'b1, 8'h00, 8'hFF, 8'h77, 0,  8'h00, 1'b0, 1};
        vt[5] = '{1'b0, 8'hFF, 8'h00, 8'h81, 3,  8'h81, 1'b0, 3};
        vt[6] = '{1'b1, 8'hFF, 8'h00, 8'h99, 0,  8'h00, 1'b0, 1};

        rst = 1'b1; clken = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        auto_resp = 1'b0; io_drv = 1'b0; dbus_drv = '0;
        cmd_valid = 1'b1;
        tick(); tick();
        check("reset_cmd_ready", cmd_ready, 0);
        check("reset_outputs", {ramadr, ramre, ramwe, dm_sel, dbus_out, rsp_valid, rsp_rdata, rsp_err, busy}, 0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("reset_release_idle", {busy, rsp_valid}, 0);

        for (int i = 0; i < 7; i++) begin
            run_txn(vt[i], $sformatf("vec%0d", i));
        end

        // clken 1,0,0,1 across a write: strobe held, single completion
        push(1'b1, 8'h55, 8'h3A, "clken");
        clken = 1'b0;
        tick();
        check("clken_ramwe_a", {ramwe, ramre, ramadr, dbus_out}, {1'b1, 1'b0, 8'h55, 8'h3A});
        tick();
        check("clken_ramwe_b", {ramwe, rsp_valid}, {1'b1, 1'b0});
        clken = 1'b1;
        tick();
        check("clken_done", {ramwe, rsp_valid, rsp_err, rsp_rdata}, {1'b0, 1'b1, 1'b0, 8'h00});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("clken_rsp_drop", {rsp_valid, ramwe}, 0);

        // queue fill: one command stalled in RESP, then four more fill the queue
        auto_resp = 1'b1;
        push(1'b0, 8'h10, 8'h00, "fill0");
        seen = 0;
        while (!rsp_valid && seen < 20) begin seen++; tick(); end
        check("fill_stall_valid", rsp_valid, 1);
        for (int i = 1; i < 5; i++) begin
            push(1'b0, 8'(8'h10 + i), 8'h00, $sformatf("fill%0d", i));
        end
        check("fill_full_ready", cmd_ready, 0);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h99;
        tick(); tick();
        check("fill_still_full", {cmd_ready, busy}, {1'b0, 1'b1});
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 60; c++) begin
            if (rsp_valid) begin
                if (got < 5) check($sformatf("order_rdata%0d", got), rsp_rdata, 8'(8'h10 + got) ^ 8'h5A);
                got++;
            end
            tick();
        end
        rsp_ready = 1'b0;
        check("order_count", got, 5);
        check("order_ready_back", {cmd_ready, busy}, {1'b1, 1'b0});
        auto_resp = 1'b0;

        // reset during a read strobe with three reads still queued
        io_drv = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(1'b0, 8'(8'h30 + i), 8'h00, $sformatf("rstq%0d", i));
        end
        check("rst_pre_ramre", {ramre, busy}, {1'b1, 1'b1});
        rst = 1'b1;
        tick();
        check("rst_bus_clear", {ramre, ramwe, dm_sel, ramadr, dbus_out}, 0);
        check("rst_busy_rsp", {busy, rsp_valid, cmd_ready}, 0);
        rst = 1'b0;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (rsp_valid || ramre || ramwe || busy) seen++;
        end
        check("rst_no_activity", seen, 0);
        run_txn(vt[1], "post_rst_read");
        run_txn(vt[0], "post_rst_write");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
